// File: rtl/alu_iter_if.sv
// Operation/result handshake bundle for the iterative execute unit.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic             sra;
  logic             slt_signed;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (
    output in_valid, ALUControl, sra, slt_signed, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  in_valid, ALUControl, sra, slt_signed, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle integer execute unit: single-cycle logic/arith/compare,
// 1-bit-per-cycle serial shifter, valid/ready on both sides.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_iter_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_step, result, alu_out;
  logic [SHW-1:0]   cnt, shamt;
  logic             shl, arith, zero_q, valid_q;
  logic             is_shift, start_shift, slt_lt;

  assign shamt       = bus.SrcB[SHW-1:0];
  assign is_shift    = (bus.ALUControl == 3'b101) || (bus.ALUControl == 3'b111);
  assign start_shift = is_shift && (shamt != '0);
  assign slt_lt      = bus.slt_signed ? ($signed(bus.SrcA) < $signed(bus.SrcB))
                                      : (bus.SrcA < bus.SrcB);

  // Single-cycle result for every op; shifts by 0 pass SrcA through.
  always_comb begin
    alu_out = '0;
    case (bus.ALUControl)
      3'b000:  alu_out = bus.SrcA + bus.SrcB;
      3'b001:  alu_out = bus.SrcA - bus.SrcB;
      3'b010:  alu_out = bus.SrcA & bus.SrcB;
      3'b011:  alu_out = bus.SrcA | bus.SrcB;
      3'b100:  alu_out = bus.SrcA ^ bus.SrcB;
      3'b110:  alu_out = {{(WIDTH-1){1'b0}}, slt_lt};
      default: alu_out = bus.SrcA;
    endcase
  end

  // One serial shift step in the captured direction and fill.
  always_comb begin
    if (shl) acc_step = {acc[WIDTH-2:0], 1'b0};
    else     acc_step = {arith & acc[WIDTH-1], acc[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and in_ready.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial shifting and registered result/flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      cnt     <= '0;
      shl     <= 1'b0;
      arith   <= 1'b0;
      result  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (start_shift) begin
              acc   <= bus.SrcA;
              cnt   <= shamt;
              shl   <= (bus.ALUControl == 3'b111);
              arith <= bus.sra;
            end else begin
              result <= alu_out;
              zero_q <= (alu_out == '0);
            end
          end
        end
        SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result <= acc_step;
            zero_q <= (acc_step == '0);
          end
        end
        default: ;
      endcase
      valid_q <= (state_nxt == DONE);
    end
  end

  assign bus.ALUResult = result;
  assign bus.Zero      = zero_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter.
module tb_alu_iter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(32)) bus();

  alu_iter #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Issue one op in IDLE, then scramble the inputs; lat counts clock edges
  // from the accept edge (inclusive) until out_valid is seen, 999 on timeout.
  task automatic run_op(input logic [2:0] op, input logic s_ra, input logic s_sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    bus.ALUControl = op;
    bus.sra        = s_ra;
    bus.slt_signed = s_sgn;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.in_valid   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      bus.in_valid   = 1'b0;
      bus.ALUControl = ~op;
      bus.sra        = ~s_ra;
      bus.slt_signed = ~s_sgn;
      bus.SrcA       = ~a;
      bus.SrcB       = ~b;
    end while (bus.out_valid !== 1'b1 && lat < 100);
    if (bus.out_valid !== 1'b1 || w >= 100) lat = 999;
    res = bus.ALUResult;
    z   = bus.Zero;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.Zero} !== 3'b100) begin
      fails++; $display("FAIL reset_flags got in_ready/out_valid/Zero=%b exp=100",
                        {bus.in_ready, bus.out_valid, bus.Zero});
    end
    tests++;
    if (bus.ALUResult !== 32'h0) begin
      fails++; $display("FAIL reset_result got=%h exp=%h", bus.ALUResult, 32'h0);
    end
    #5 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    logic [31:0] r; logic z; int lat;
    run_op(3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, r, z, lat);
    tests++;
    if ({r, z} !== {32'h0, 1'b1}) begin
      fails++; $display("FAIL add_wrap got=%h/%b exp=00000000/1", r, z);
    end
    tests++;
    if (lat !== 1) begin
      fails++; $display("FAIL add_wrap_latency got=%0d exp=1", lat);
    end
    consume();
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++; $display("FAIL add_handoff got out_valid/in_ready=%b exp=01",
                        {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_sub_cmp();
    logic [2:0]  ops [4] = '{3'b001, 3'b001, 3'b110, 3'b110};
    logic        sgn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] a   [4] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b   [4] = '{32'd5, 32'd5, 32'd1, 32'd1};
    logic [31:0] er  [4] = '{32'd0, 32'hFFFF_FFFE, 32'd1, 32'd0};
    logic        ez  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] r; logic z; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 1'b0, sgn[i], a[i], b[i], r, z, lat);
      tests++;
      if ({r, z} !== {er[i], ez[i]} || lat !== 1) begin
        fails++; $display("FAIL sub_cmp[%0d] got=%h/%b lat=%0d exp=%h/%b lat=1",
                          i, r, z, lat, er[i], ez[i]);
      end
      consume();
    end
  endtask

  task automatic test_shifts();
    logic [2:0]  ops [5] = '{3'b101, 3'b101, 3'b111, 3'b101, 3'b101};
    logic        sa  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] a   [5] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h4000_0000, 32'hFFFF_FFFF};
    logic [31:0] b   [5] = '{32'd31, 32'd31, 32'h25, 32'd2, 32'hFFFF_FFE1};
    logic [31:0] er  [5] = '{32'hFFFF_FFFF, 32'h1, 32'h20, 32'h1000_0000, 32'h7FFF_FFFF};
    int          el  [5] = '{32, 32, 6, 3, 2};
    logic [31:0] r; logic z; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], sa[i], 1'b0, a[i], b[i], r, z, lat);
      tests++;
      if (r !== er[i] || z !== 1'b0) begin
        fails++; $display("FAIL shift[%0d] got=%h/%b exp=%h/0", i, r, z, er[i]);
      end
      tests++;
      if (lat !== el[i]) begin
        fails++; $display("FAIL shift_latency[%0d] got=%0d exp=%0d", i, lat, el[i]);
      end
      consume();
    end
  endtask

  task automatic test_zero_shift_logic();
    logic [2:0]  ops [4] = '{3'b111, 3'b010, 3'b011, 3'b100};
    logic [31:0] a   [4] = '{32'h1234_5678, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
    logic [31:0] b   [4] = '{32'h20, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00};
    logic [31:0] er  [4] = '{32'h1234_5678, 32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0};
    logic [31:0] r; logic z; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 1'b0, 1'b0, a[i], b[i], r, z, lat);
      tests++;
      if (r !== er[i] || z !== 1'b0 || lat !== 1) begin
        fails++; $display("FAIL logic[%0d] got=%h/%b lat=%0d exp=%h/0 lat=1",
                          i, r, z, lat, er[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic z; int lat;
    run_op(3'b000, 1'b0, 1'b0, 32'd2, 32'd3, r, z, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({bus.out_valid, bus.in_ready, bus.ALUResult, bus.Zero} !== {2'b10, 32'd5, 1'b0}) begin
        fails++; $display("FAIL hold[%0d] got ov/ir=%b res=%h z=%b exp 10/00000005/0",
                          i, {bus.out_valid, bus.in_ready}, bus.ALUResult, bus.Zero);
      end
    end
    consume();
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++; $display("FAIL release got out_valid/in_ready=%b exp=01",
                        {bus.out_valid, bus.in_ready});
    end
    run_op(3'b000, 1'b0, 1'b0, 32'd7, 32'd8, r, z, lat);
    tests++;
    if (r !== 32'd15 || lat !== 1) begin
      fails++; $display("FAIL back_to_back got=%h lat=%0d exp=0000000f lat=1", r, lat);
    end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r; logic z; int lat; int seen;
    bus.ALUControl = 3'b101;
    bus.sra        = 1'b0;
    bus.SrcA       = 32'hFFFF_FFFF;
    bus.SrcB       = 32'd20;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    tests++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
      fails++; $display("FAIL mid_shift got in_ready/out_valid=%b exp=00",
                        {bus.in_ready, bus.out_valid});
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.ALUResult} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL async_reset got ir/ov=%b res=%h exp=10/00000000",
                        {bus.in_ready, bus.out_valid}, bus.ALUResult);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL stale_result got out_valid high %0d cycles exp=0", seen);
    end
    run_op(3'b000, 1'b0, 1'b0, 32'd1, 32'd1, r, z, lat);
    tests++;
    if (r !== 32'd2 || z !== 1'b0 || lat !== 1) begin
      fails++; $display("FAIL post_reset_add got=%h/%b lat=%0d exp=00000002/0 lat=1", r, z, lat);
    end
    consume();
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.ALUControl = 3'b000;
    bus.sra        = 1'b0;
    bus.slt_signed = 1'b0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub_cmp();
    test_shifts();
    test_zero_shift_logic();
    test_backpressure();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
